call_scheduler: RTL

Request scheduler for the elevator car. It latches interior and exterior panel calls into a pending-request register and tracks the car's floor and travel direction. It sequences the movement block one floor step at a time over a valid/ready handshake, and holds doors open for a fixed dwell. It sits between the panels and the engine-driving movement controller, and is the only block that decides where the car goes next.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/dwell_timer.sv | 31 +++
 rtl/call_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call scheduler and its movement block.
// Floor vectors are indexed by floor number, floor 0 being the ground floor.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP_REQ,
    ST_MOVING,
    ST_DOOR_OPEN
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] ENG_OFF  = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b10;
  localparam logic [1:0] ENG_DOWN = 2'b11;

  localparam int DEFAULT_FLOORS = 3;
  localparam int MAX_FLOORS     = 32;

  // Marks floors strictly above (dir=1) or strictly below (dir=0) the given floor.
  function automatic logic [MAX_FLOORS-1:0] beyond_mask(input logic [31:0] floor,
                                                        input logic dir);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      m[i] = dir ? (i > floor) : (i < floor);
    end
    return m;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Door dwell timer: loadable down-counter that flags the last cycle of the hold.
// A load always wins over expiry so a re-press extends the hold.
module dwell_timer
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DWELL_CYCLES);
    end else if (busy && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = busy && (count == CW'(1));

endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches panel calls, picks the next floor step and
// sequences the movement block one floor at a time, holding doors for a dwell.
module call_scheduler
  import elevator_pkg::*;
#(
  parameter  int FLOORS       = DEFAULT_FLOORS,
  parameter  int DWELL_CYCLES = 8,
  localparam int FW           = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLOORS-1:0] interior_panel,
  input  logic [FLOORS-1:0] exterior_panel,
  output logic              step_valid,
  output logic              step_dir,
  input  logic              step_ready,
  input  logic              step_done,
  output logic [FLOORS-1:0] doors,
  output logic [FW-1:0]     cur_floor,
  output logic              direction,
  output logic [FLOORS-1:0] pending
);

  state_t state, state_n;

  logic [FLOORS-1:0]     pending_n, press, here_mask, arrive_mask;
  logic [FLOORS-1:0]     clear_mask, suppress_mask;
  logic [FW-1:0]         cur_floor_n, next_floor;
  logic                  direction_n, dwell_load, dwell_expired, at_limit;
  logic [MAX_FLOORS-1:0] pend_wide;
  logic                  calls_ahead, calls_behind, calls_past_next;

  assign press       = interior_panel | exterior_panel;
  assign pend_wide   = MAX_FLOORS'(pending);
  assign here_mask   = FLOORS'(1) << cur_floor;
  assign next_floor  = (direction == DIR_UP) ? cur_floor + FW'(1) : cur_floor - FW'(1);
  assign arrive_mask = FLOORS'(1) << next_floor;
  assign at_limit    = (direction == DIR_UP) ? (cur_floor == FW'(FLOORS - 1))
                                             : (cur_floor == '0);

  assign calls_ahead     = |(pend_wide & beyond_mask(32'(cur_floor), direction));
  assign calls_behind    = |(pend_wide & beyond_mask(32'(cur_floor), ~direction));
  assign calls_past_next = |(pend_wide & beyond_mask(32'(next_floor), direction));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pending   <= '0;
      cur_floor <= '0;
      direction <= DIR_UP;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      cur_floor <= cur_floor_n;
      direction <= direction_n;
    end
  end

  always_comb begin
    state_n       = state;
    direction_n   = direction;
    cur_floor_n   = cur_floor;
    clear_mask    = '0;
    dwell_load    = 1'b0;
    suppress_mask = '0;
    case (state)
      ST_IDLE: begin
        if (pending[cur_floor]) begin
          state_n    = ST_DOOR_OPEN;
          clear_mask = here_mask;
          dwell_load = 1'b1;
        end else if (calls_ahead) begin
          state_n = ST_STEP_REQ;
        end else if (calls_behind) begin
          direction_n = ~direction;
          state_n     = ST_STEP_REQ;
        end
      end
      ST_STEP_REQ: begin
        if (step_ready) state_n = ST_MOVING;
      end
      ST_MOVING: begin
        if (step_done) begin
          // A step past the shaft end cannot be requested; treat it as a no-op arrival.
          if (at_limit) begin
            state_n = ST_IDLE;
          end else begin
            cur_floor_n = next_floor;
            if (pending[next_floor]) begin
              state_n    = ST_DOOR_OPEN;
              clear_mask = arrive_mask;
              dwell_load = 1'b1;
            end else if (calls_past_next) begin
              state_n = ST_STEP_REQ;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR_OPEN: begin
        suppress_mask = here_mask;
        if (press[cur_floor]) begin
          dwell_load = 1'b1;
        end else if (dwell_expired) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    pending_n = (pending | (press & ~suppress_mask)) & ~clear_mask;
  end

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (dwell_load),
    .busy    (state == ST_DOOR_OPEN),
    .expired (dwell_expired)
  );

  assign step_valid = (state == ST_STEP_REQ);
  assign step_dir   = direction;
  assign doors      = (state == ST_DOOR_OPEN) ? here_mask : '0;

endmodule
